pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain.sv | 154 +++++++++++++++
 tb/tb_pipe_chain.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain.sv
// pipe_chain: elastic valid/ready register pipeline of DEPTH stages.
// Stage 0 is the youngest stage and stage DEPTH-1 drives out_data.
// Items advance whenever the stage ahead is empty or is itself advancing,
// so bubbles collapse. Per-stage flush squashes stages. A global stall
// freezes every stage.
// Optional feature: define PIPE_STATS_EN to build the saturating
// stall/bubble statistics counters. Without it, both counters read
// constant zero and clr_stats is ignored.
module pipe_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stall,
    input  logic [DEPTH-1:0] flush,
    output logic [DEPTH-1:0] stage_valid,
    output logic [4:0]       occupancy,
    input  logic             clr_stats,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      bubble_cnt
);

    // Population count of the per-stage valid bits.
    function automatic logic [4:0] count_ones(input logic [DEPTH-1:0] vec);
        logic [4:0] acc;
        acc = 5'd0;
        for (int i = 0; i < DEPTH; i++) begin
            acc = acc + {4'd0, vec[i]};
        end
        return acc;
    endfunction

    logic [DEPTH-1:0] valid_r;
    logic [WIDTH-1:0] data_r [DEPTH];
    logic [DEPTH-1:0] ready_s;
    logic [DEPTH-1:0] up_valid_s;
    logic [WIDTH-1:0] up_data_s [DEPTH];

    // Ready chain, walked from the oldest stage back to stage 0.
    // A running variable avoids feeding the vector back into itself.
    always_comb begin
        logic chain_s;
        ready_s = {DEPTH{1'b0}};
        chain_s = !stall && (!valid_r[DEPTH-1] || out_ready);
        ready_s[DEPTH-1] = chain_s;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            chain_s = !stall && (!valid_r[i] || chain_s);
            ready_s[i] = chain_s;
        end
    end

    // Upstream offer seen by each stage.
    // A flushed stage never hands its old item forward.
    always_comb begin
        up_valid_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            up_data_s[i] = {WIDTH{1'b0}};
        end
        up_valid_s[0] = in_valid;
        up_data_s[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_valid_s[i] = valid_r[i-1] && !flush[i-1];
            up_data_s[i]  = data_r[i-1];
        end
    end

    // Stage registers.
    // Flush wins over everything; otherwise a stage loads when ready and holds when not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush[i]) begin
                    valid_r[i] <= 1'b0;
                end else if (ready_s[i]) begin
                    valid_r[i] <= up_valid_s[i];
                    data_r[i]  <= up_data_s[i];
                end else begin
                    valid_r[i] <= valid_r[i];
                end
            end
        end
    end

    assign in_ready    = ready_s[0];
    assign out_valid   = valid_r[DEPTH-1] && !stall;
    assign out_data    = data_r[DEPTH-1];
    assign stage_valid = valid_r;
    assign occupancy   = count_ones(valid_r);

`ifdef PIPE_STATS_EN
    // Saturating increment shared by both statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        logic [15:0] res;
        if (cnt == 16'hFFFF) begin
            res = cnt;
        end else begin
            res = cnt + 16'd1;
        end
        return res;
    endfunction

    logic        stall_evt_s;
    logic        bubble_evt_s;
    logic [15:0] stall_cnt_r;
    logic [15:0] bubble_cnt_r;

    assign stall_evt_s  = stall || (valid_r[DEPTH-1] && !out_ready);
    assign bubble_evt_s = !valid_r[DEPTH-1] && (occupancy != 5'd0);

    // Statistics counters; clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r  <= 16'd0;
            bubble_cnt_r <= 16'd0;
        end else if (clr_stats) begin
            stall_cnt_r  <= 16'd0;
            bubble_cnt_r <= 16'd0;
        end else begin
            if (stall_evt_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (bubble_evt_s) begin
                bubble_cnt_r <= sat_inc(bubble_cnt_r);
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
        end
    end

    assign stall_cnt  = stall_cnt_r;
    assign bubble_cnt = bubble_cnt_r;
`else
    logic stats_unused_s;

    assign stats_unused_s = clr_stats;
    assign stall_cnt      = 16'd0;
    assign bubble_cnt     = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Scoreboard bench for pipe_chain (DEPTH=4, WIDTH=8).
// Stimulus pushes the expected items. A negedge monitor pops and compares
// every item that is delivered.
module tb_pipe_chain;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = 8'h00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         stall = 1'b0;
    logic [D-1:0] flush = 4'b0000;
    logic [D-1:0] stage_valid;
    logic [4:0]   occupancy;
    logic         clr_stats = 1'b0;
    logic [15:0]  stall_cnt;
    logic [15:0]  bubble_cnt;

    int           pass_cnt = 0;
    int           total_cnt = 0;
    logic [W-1:0] expq [$];
    logic [W-1:0] mon_exp;

    pipe_chain #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .stall(stall), .flush(flush),
        .stage_valid(stage_valid), .occupancy(occupancy), .clr_stats(clr_stats),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 4'b0000;
        for (int n = 0; n < 20 && occupancy != 5'd0; n++) tick();
        chk("drain_empty", 32'(occupancy), 32'd0);
    endtask

    // Monitor: every delivered item must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected: actual=%0h required=no item", out_data);
            end else begin
                mon_exp = expq.pop_front();
                chk("sb_data", 32'(out_data), 32'(mon_exp));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_stage_valid", 32'(stage_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Streaming 0x11..0x14: outputs on cycles 4..7, gap-free
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                in_valid = 1'b1; in_data = 8'(8'h11 + k); expq.push_back(8'(8'h11 + k));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("t1_out_valid", 32'(out_valid), 32'(k >= 4));
            if (k >= 4) chk("t1_out_data", 32'(out_data), 32'(8'h11 + k - 4));
            tick();
        end
        chk("t1_empty", 32'(occupancy), 32'd0);

        // Item entering a flushed stage 0 is dropped, handshake still completes
        in_valid = 1'b1; in_data = 8'h61; flush = 4'b0001;
        @(negedge clk);
        chk("fl0_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; flush = 4'b0000;
        chk("fl0_dropped", 32'(stage_valid), 32'd0);
        in_valid = 1'b1; in_data = 8'h62; expq.push_back(8'h62);
        tick();
        drain();

        // Full pipe with out_ready=0, then a single-cycle release
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'(8'h21 + k); expq.push_back(8'(8'h21 + k));
            tick();
        end
        in_data = 8'h25;
        @(negedge clk);
        chk("t2_full_in_ready", 32'(in_ready), 32'd0);
        chk("t2_full_occ", 32'(occupancy), 32'd4);
        tick();
        out_ready = 1'b1; expq.push_back(8'h25);
        @(negedge clk);
        chk("t2_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t2_after_occ", 32'(occupancy), 32'd4);
        chk("t2_after_in_ready", 32'(in_ready), 32'd0);
        chk("t2_after_head", 32'(out_data), 32'h22);
        tick();
        drain();

        // Three items in stages 0,2,3; flush 0110 under stall keeps 0 and 3
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h31; expq.push_back(8'h31); tick();
        in_data = 8'h32; tick();
        in_valid = 1'b0; tick();
        tick();
        in_valid = 1'b1; in_data = 8'h33; expq.push_back(8'h33); tick();
        in_valid = 1'b0;
        chk("t3_before", 32'(stage_valid), 32'b1101);
        stall = 1'b1; flush = 4'b0110;
        tick();
        stall = 1'b0; flush = 4'b0000;
        chk("t3_after", 32'(stage_valid), 32'b1001);
        chk("t3_occ", 32'(occupancy), 32'd2);
        drain();

        // Five stall cycles on a full pipe
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'(8'h41 + k); expq.push_back(8'(8'h41 + k));
            tick();
        end
        in_valid = 1'b0; clr_stats = 1'b1;
        chk("t4_full_occ", 32'(occupancy), 32'd4);
        tick();
        clr_stats = 1'b0; stall = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h99;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_out_valid", 32'(out_valid), 32'd0);
            chk("t4_in_ready", 32'(in_ready), 32'd0);
            chk("t4_frozen", 32'(stage_valid), 32'hF);
            tick();
        end
        stall = 1'b0; in_valid = 1'b0;
`ifdef PIPE_STATS_EN
        chk("t4_stall_cnt", 32'(stall_cnt), 32'd5);
`else
        chk("t4_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        drain();

        // Asynchronous reset mid-stream
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h51; expq.push_back(8'h51); tick();
        in_data = 8'h52; expq.push_back(8'h52); tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_stage_valid", 32'(stage_valid), 32'd0);
        chk("t5_rst_occ", 32'(occupancy), 32'd0);
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        expq.delete();
        tick();
        chk("t5_rst_held", 32'(stage_valid), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                in_valid = 1'b1; in_data = 8'h55; expq.push_back(8'h55);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("t5_latency", 32'(out_valid), 32'(k == 4));
            tick();
        end
        drain();

        // Statistics counters
`ifdef PIPE_STATS_EN
        stall = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("t6_stall_sat", 32'(stall_cnt), 32'hFFFF);
        stall = 1'b0; clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("t6_stall_clr", 32'(stall_cnt), 32'd0);
        chk("t6_bubble_clr", 32'(bubble_cnt), 32'd0);
`else
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("t6_stall_zero", 32'(stall_cnt), 32'd0);
        chk("t6_bubble_zero", 32'(bubble_cnt), 32'd0);
`endif

        chk("sb_left", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
